// File: rtl/iob_reg_tmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob_reg_tmr_pkg
//  Description : Shared types and helpers for the N-modular-redundant
//                scrubbing register: FSM state encoding, per-bit majority
//                vote, population count and parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package iob_reg_tmr_pkg;

    // Largest supported replica count. Vote columns are zero-padded to this.
    localparam int MAX_REPL = 7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SCRUB = 2'd1,
        FAULT = 2'd2
    } tmr_state_t;

    // Number of set bits in a (zero-padded) replica column.
    function automatic logic [2:0] popcount(input logic [MAX_REPL-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < MAX_REPL; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Majority of one bit position across n replicas.
    function automatic logic maj_vote(input logic [MAX_REPL-1:0] column,
                                      input int n);
        return (int'(popcount(column)) > (n / 2));
    endfunction

    // Odd replica count in 3..MAX_REPL, persistence threshold in 1..15.
    function automatic logic params_ok(input int n, input int th);
        return (n >= 3) && (n <= MAX_REPL) && ((n % 2) == 1) &&
               (th >= 1) && (th <= 15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_tmr_voter.sv
`default_nettype none
// ============================================================================
//  Module      : iob_tmr_voter
//  Description : Purely combinational bitwise majority voter over N replicas.
//                Produces the voted word, a per-replica disagreement mask and
//                the number of replicas that equal the voted word.
//  Ports       : i_repl      - packed array of N_REPL replica words
//                o_data      - bitwise majority
//                o_err_loc   - bit i set when replica i differs from o_data
//                o_match_cnt - count of replicas equal to o_data
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_tmr_voter
    import iob_reg_tmr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_REPL = 3
) (
    input  logic [N_REPL-1:0][DATA_W-1:0] i_repl,
    output logic [DATA_W-1:0]             o_data,
    output logic [N_REPL-1:0]             o_err_loc,
    output logic [2:0]                    o_match_cnt
);

    logic [MAX_REPL-1:0] w_match_vec;

    always_comb begin
        logic [MAX_REPL-1:0] w_col;
        o_data = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_col = '0;
            for (int r = 0; r < N_REPL; r++) begin
                w_col[r] = i_repl[r][b];
            end
            o_data[b] = maj_vote(w_col, N_REPL);
        end
    end

    for (genvar r = 0; r < N_REPL; r++) begin : g_cmp
        assign o_err_loc[r] = (i_repl[r] != o_data);
    end

    always_comb begin
        w_match_vec                = '0;
        w_match_vec[N_REPL-1:0]    = ~o_err_loc;
    end

    assign o_match_cnt = popcount(w_match_vec);

endmodule
`default_nettype wire

// File: rtl/iob_reg_re_tmr_scrub.sv
`default_nettype none
// ============================================================================
//  Module      : iob_reg_re_tmr_scrub
//  Description : N-modular-redundant register with enable, bitwise majority
//                voting, active scrubbing of correctable upsets, sticky
//                uncorrectable-error flag, dead-replica detection and a
//                saturating corrected-error counter.
//  Ports       : clk_i, rst_i (sync, active-high), cke_i (global hold),
//                en_i/data_i (write), err_clr_i (clear error state),
//                data_o (voted value), err_loc_o, min_err_o (combinational),
//                maj_err_o, scrub_o, dead_o, corr_cnt_o (registered).
//  Options     : IOB_REG_RE_TMR_ERR_CNT_EN - builds the corrected-error
//                counter and dead-replica logic; otherwise dead_o and
//                corr_cnt_o are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_reg_re_tmr_scrub
    import iob_reg_tmr_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RST_VAL    = '0,
    parameter int                N_REPL     = 3,
    parameter int                PERSIST_TH = 4,
    parameter int                CNT_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic [N_REPL-1:0] err_loc_o,
    output logic              min_err_o,
    output logic              maj_err_o,
    output logic              scrub_o,
    output logic [N_REPL-1:0] dead_o,
    output logic [CNT_W-1:0]  corr_cnt_o
);

    if (!params_ok(N_REPL, PERSIST_TH)) begin : g_param_check
        $error("iob_reg_re_tmr_scrub: illegal N_REPL or PERSIST_TH");
    end

    logic [N_REPL-1:0][DATA_W-1:0] w_repl;
    logic [DATA_W-1:0]             w_vote;
    logic [N_REPL-1:0]             w_err_loc;
    logic [2:0]                    w_match;
    logic [N_REPL-1:0]             w_dead;
    logic                          w_uncorr;
    logic                          w_live;
    logic                          w_load;
    logic [DATA_W-1:0]             w_load_data;
    tmr_state_t                    r_state;

    iob_tmr_voter #(
        .DATA_W (DATA_W),
        .N_REPL (N_REPL)
    ) u_voter (
        .i_repl      (w_repl),
        .o_data      (w_vote),
        .o_err_loc   (w_err_loc),
        .o_match_cnt (w_match)
    );

    assign w_uncorr = (int'(w_match) < ((N_REPL + 1) / 2));
    // Dead replicas still vote, but no longer request repair or counting.
    assign w_live   = |(w_err_loc & ~w_dead);

    // A write always wins over the scrub write-back and repairs the upset.
    assign w_load      = en_i | (r_state == SCRUB);
    assign w_load_data = en_i ? data_i : w_vote;

    // Each replica reassigns itself when idle so that an externally upset
    // value persists until a write or scrub overwrites it.
    for (genvar i = 0; i < N_REPL; i++) begin : gen_repl
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q <= RST_VAL;
            end else if (cke_i && w_load) begin
                q <= w_load_data;
            end else begin
                q <= q;
            end
        end
        assign w_repl[i] = q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else if (cke_i) begin
            // A clear is applied first; any new error is seen next cycle.
            if (err_clr_i) begin
                r_state <= RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_uncorr) begin
                            r_state <= FAULT;
                        end else if (w_live && !en_i) begin
                            r_state <= SCRUB;
                        end
                    end
                    SCRUB:   r_state <= w_uncorr ? FAULT : RUN;
                    FAULT:   r_state <= FAULT;
                    default: r_state <= RUN;
                endcase
            end
        end
    end

`ifdef IOB_REG_RE_TMR_ERR_CNT_EN
    localparam logic [3:0] c_th = 4'(PERSIST_TH);

    logic [CNT_W-1:0]       r_corr_cnt;
    logic [N_REPL-1:0]      r_dead;
    logic [N_REPL-1:0][3:0] r_mm_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_corr_cnt <= '0;
            r_dead     <= '0;
            r_mm_cnt   <= '0;
        end else if (cke_i) begin
            if (err_clr_i) begin
                r_corr_cnt <= '0;
                r_dead     <= '0;
                r_mm_cnt   <= '0;
            end else begin
                if ((r_state == RUN) && w_live && !w_uncorr &&
                    (r_corr_cnt != '1)) begin
                    r_corr_cnt <= r_corr_cnt + 1'b1;
                end
                // Run-length of consecutive mismatches; saturates at c_th.
                for (int i = 0; i < N_REPL; i++) begin
                    if (w_err_loc[i]) begin
                        if (r_mm_cnt[i] != c_th) begin
                            r_mm_cnt[i] <= r_mm_cnt[i] + 4'd1;
                        end
                        if (r_mm_cnt[i] == (c_th - 4'd1)) begin
                            r_dead[i] <= 1'b1;
                        end
                    end else begin
                        r_mm_cnt[i] <= 4'd0;
                    end
                end
            end
        end
    end

    assign w_dead     = r_dead;
    assign corr_cnt_o = r_corr_cnt;
`else
    assign w_dead     = '0;
    assign corr_cnt_o = '0;
`endif

    assign dead_o    = w_dead;
    assign data_o    = w_vote;
    assign err_loc_o = w_err_loc;
    assign min_err_o = |w_err_loc;
    assign maj_err_o = (r_state == FAULT);
    assign scrub_o   = (r_state == SCRUB);

endmodule
`default_nettype wire

// File: tb/tb_iob_reg_re_tmr_scrub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_reg_re_tmr_scrub
//  Description : Directed self-checking bench for iob_reg_re_tmr_scrub with
//                DATA_W=8, N_REPL=3, RST_VAL=8'h5A, PERSIST_TH=4, CNT_W=8.
//                Expectations for dead_o/corr_cnt_o follow the
//                IOB_REG_RE_TMR_ERR_CNT_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_reg_re_tmr_scrub;

`ifdef IOB_REG_RE_TMR_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cke;
    logic       en;
    logic       err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [2:0] err_loc;
    logic       min_err;
    logic       maj_err;
    logic       scrub;
    logic [2:0] dead;
    logic [7:0] corr_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_reg_re_tmr_scrub #(
        .DATA_W     (8),
        .RST_VAL    (8'h5A),
        .N_REPL     (3),
        .PERSIST_TH (4),
        .CNT_W      (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cke_i      (cke),
        .en_i       (en),
        .data_i     (data_in),
        .err_clr_i  (err_clr),
        .data_o     (data_out),
        .err_loc_o  (err_loc),
        .min_err_o  (min_err),
        .maj_err_o  (maj_err),
        .scrub_o    (scrub),
        .dead_o     (dead),
        .corr_cnt_o (corr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic check_repl(input string tag, input logic [7:0] exp);
        check({tag, "_r0"}, 32'(dut.gen_repl[0].q), 32'(exp));
        check({tag, "_r1"}, 32'(dut.gen_repl[1].q), 32'(exp));
        check({tag, "_r2"}, 32'(dut.gen_repl[2].q), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        step();
        step();
        rst = 1'b0;
        check("rst_data",    32'(data_out), 32'h5A);
        check("rst_err_loc", 32'(err_loc),  32'h0);
        check("rst_min_err", 32'(min_err),  32'h0);
        check("rst_maj_err", 32'(maj_err),  32'h0);
        check("rst_scrub",   32'(scrub),    32'h0);
        check("rst_dead",    32'(dead),     32'h0);
        check("rst_cnt",     32'(corr_cnt), 32'h0);

        // Test 1: write latency of one cycle
        en = 1'b1; data_in = 8'h3C;
        step();
        en = 1'b0;
        check("wr_data", 32'(data_out), 32'h3C);

        // cke low holds the replicas even with a write pending
        cke = 1'b0; en = 1'b1; data_in = 8'h77;
        step();
        check("cke_hold", 32'(data_out), 32'h3C);
        cke = 1'b1; en = 1'b0;

        // Test 2: single correctable upset on replica 1
        force dut.gen_repl[1].q = 8'hFF;
        #1 release dut.gen_repl[1].q;
        #1;
        check("up_err_loc", 32'(err_loc),  32'h2);
        check("up_min_err", 32'(min_err),  32'h1);
        check("up_data",    32'(data_out), 32'h3C);
        step();
        check("up_scrub",   32'(scrub),    32'h1);
        check("up_r1_bad",  32'(dut.gen_repl[1].q), 32'hFF);
        check("up_cnt",     32'(corr_cnt), cnt_exp(1));
        step();
        check("up_scrub_done", 32'(scrub), 32'h0);
        check_repl("up_fixed", 8'h3C);
        check("up_err_clear", 32'(err_loc),  32'h0);
        check("up_cnt_hold",  32'(corr_cnt), cnt_exp(1));

        // Test 3: uncorrectable upset
        force dut.gen_repl[0].q = 8'h00;
        force dut.gen_repl[1].q = 8'h0F;
        force dut.gen_repl[2].q = 8'hF0;
        #1;
        release dut.gen_repl[0].q;
        release dut.gen_repl[1].q;
        release dut.gen_repl[2].q;
        #1;
        check("unc_data",    32'(data_out),    32'h00);
        check("unc_err_loc", 32'(err_loc),     32'h6);
        check("unc_match",   32'(dut.w_match), 32'h1);
        check("unc_maj_pre", 32'(maj_err),     32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("unc_maj",   32'(maj_err), 32'h1);
            check("unc_noscr", 32'(scrub),   32'h0);
        end
        check("unc_dead", 32'(dead),     CNT_EN ? 32'h6 : 32'h0);
        check("unc_cnt",  32'(corr_cnt), cnt_exp(1));
        err_clr = 1'b1; en = 1'b1; data_in = 8'h3C;
        step();
        err_clr = 1'b0; en = 1'b0;
        check("clr_maj",     32'(maj_err),  32'h0);
        check("clr_dead",    32'(dead),     32'h0);
        check("clr_cnt",     32'(corr_cnt), 32'h0);
        check("clr_data",    32'(data_out), 32'h3C);
        check("clr_err_loc", 32'(err_loc),  32'h0);
        step();
        check("clr_stay_run", 32'(maj_err), 32'h0);

        // Test 4: replica 2 stuck at 8'h00
        force dut.gen_repl[2].q = 8'h00;
        #1;
        check("stk_err_loc", 32'(err_loc), 32'h4);
        step();
        check("stk_scr1", 32'(scrub),    32'h1);
        check("stk_cnt1", 32'(corr_cnt), cnt_exp(1));
        step();
        check("stk_run1", 32'(scrub),    32'h0);
        step();
        check("stk_scr2", 32'(scrub),    32'h1);
        check("stk_cnt2", 32'(corr_cnt), cnt_exp(2));
        step();
        check("stk_run2", 32'(scrub),    32'h0);
        check("stk_dead", 32'(dead),     CNT_EN ? 32'h4 : 32'h0);
        for (int j = 0; j < 4; j++) begin
            step();
            check("stk_after_scrub", 32'(scrub),
                  (!CNT_EN && (j % 2 == 0)) ? 32'h1 : 32'h0);
            check("stk_after_cnt", 32'(corr_cnt), cnt_exp(2));
        end
        release dut.gen_repl[2].q;
        en = 1'b1; data_in = 8'h3C;
        step();
        en = 1'b0;
        check_repl("stk_rewr", 8'h3C);
        check("stk_rewr_cnt", 32'(corr_cnt), cnt_exp(2));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("stk_clr_dead", 32'(dead),     32'h0);
        check("stk_clr_cnt",  32'(corr_cnt), 32'h0);

        // Test 5: upset coincident with a write
        en = 1'b1; data_in = 8'hA5;
        force dut.gen_repl[0].q = 8'hFF;
        #1 release dut.gen_repl[0].q;
        #1;
        check("wu_err_loc", 32'(err_loc),  32'h1);
        check("wu_data",    32'(data_out), 32'h3C);
        step();
        en = 1'b0;
        check("wu_noscrub", 32'(scrub),    32'h0);
        check("wu_data_new", 32'(data_out), 32'hA5);
        check_repl("wu", 8'hA5);
        check("wu_cnt",     32'(corr_cnt), cnt_exp(1));
        step();
        check("wu_noscrub2", 32'(scrub),   32'h0);
        check("wu_cnt2",     32'(corr_cnt), cnt_exp(1));

        // Test 6a: reset during SCRUB
        force dut.gen_repl[1].q = 8'h00;
        #1 release dut.gen_repl[1].q;
        step();
        check("rs_scrub", 32'(scrub),    32'h1);
        check("rs_cnt",   32'(corr_cnt), cnt_exp(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_scrub_off", 32'(scrub),    32'h0);
        check("rs_data",      32'(data_out), 32'h5A);
        check("rs_cnt0",      32'(corr_cnt), 32'h0);
        check("rs_maj",       32'(maj_err),  32'h0);
        check("rs_err_loc",   32'(err_loc),  32'h0);
        check("rs_r1",        32'(dut.gen_repl[1].q), 32'h5A);

        // Test 6b: counter saturation after 300 scrubbed upsets
        for (int n = 0; n < 300; n++) begin
            force dut.gen_repl[0].q = 8'hA5;
            #1 release dut.gen_repl[0].q;
            step();
            step();
            if (n == 254) begin
                check("sat_at_255", 32'(corr_cnt), cnt_exp(255));
            end
        end
        check("sat_cnt",   32'(corr_cnt), cnt_exp(255));
        check("sat_scrub", 32'(scrub),    32'h0);
        check("sat_data",  32'(data_out), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
